ult_sort_sequencer: RTL and testbench

Multi-cycle sorter for a block of N unsigned words, built around one shared unsigned less-than comparator (subtract/carry-out style ULT, WIDTH bits).
- Runs an in-place bubble sort, issuing exactly one compare-and-swap per cycle.
- Sits between a producer and a consumer, with a valid/ready handshake on each side.
- Serves as the sequencing controller for the ULT datapath, so only one comparator is instantiated regardless of N.

---
 rtl/ult_sort_sequencer_if.sv | 23 ++
 rtl/ult_sort_sequencer.sv | 114 +++++++++++
 tb/tb_ult_sort_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ult_sort_sequencer_if.sv
// Handshake bundle for ult_sort_sequencer: producer side (IN_*, I), consumer side (OUT_*, O) and BUSY.
interface ult_sort_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int N     = 4
);
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [N*WIDTH-1:0]   I;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [N*WIDTH-1:0]   O;
    logic                 BUSY;

    modport master (
        output IN_VALID, I, OUT_READY,
        input  IN_READY, OUT_VALID, O, BUSY
    );

    modport slave (
        input  IN_VALID, I, OUT_READY,
        output IN_READY, OUT_VALID, O, BUSY
    );
endinterface

// File: rtl/ult_sort_sequencer.sv
// In-place bubble sorter driving one shared unsigned less-than comparator, one compare-and-swap per cycle.
// Optional macro SORT_EARLY_EXIT_EN: finish as soon as a full pass makes no swap.
module ult_sort_sequencer #(
    parameter int WIDTH = 4,
    parameter int N     = 4
) (
    input  logic CLK,
    input  logic RESET,
    ult_sort_sequencer_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    e    [N];
    logic [WIDTH-1:0]    e_nx [N];
    logic [CW-1:0]       p;
    logic [CW-1:0]       j;
    logic [CW-1:0]       jn;
    logic [N*WIDTH-1:0]  o_nx;
    logic                c;
    logic                pass_end;
    logic                finish;
`ifdef SORT_EARLY_EXIT_EN
    logic                swapped;
`endif

    // Borrow out of a - b is set exactly when a < b (unsigned).
    function automatic logic ult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[WIDTH];
    endfunction

    assign jn       = j + CW'(1);
    assign pass_end = (j == CW'(N - 2) - p);
`ifdef SORT_EARLY_EXIT_EN
    assign finish   = pass_end && ((p == CW'(N - 2)) || !(swapped || c));
`else
    assign finish   = pass_end && (p == CW'(N - 2));
`endif

    always_comb begin
        for (int unsigned k = 0; k < N; k++) e_nx[k] = e[k];
        c = ult(e[jn], e[j]);
        if (state == SORT && c) begin
            e_nx[j]  = e[jn];
            e_nx[jn] = e[j];
        end
        o_nx = '0;
        for (int unsigned k = 0; k < N; k++) o_nx[k*WIDTH +: WIDTH] = e_nx[k];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            for (int unsigned k = 0; k < N; k++) e[k] <= '0;
            p             <= '0;
            j             <= '0;
            bus.O         <= '0;
            bus.OUT_VALID <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.IN_READY  <= 1'b1;
`ifdef SORT_EARLY_EXIT_EN
            swapped       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.IN_VALID && bus.IN_READY) begin
                        for (int unsigned k = 0; k < N; k++) e[k] <= bus.I[k*WIDTH +: WIDTH];
                        p            <= '0;
                        j            <= '0;
                        bus.IN_READY <= 1'b0;
                        bus.BUSY     <= 1'b1;
                        state        <= SORT;
`ifdef SORT_EARLY_EXIT_EN
                        swapped      <= 1'b0;
`endif
                    end
                end
                SORT: begin
                    for (int unsigned k = 0; k < N; k++) e[k] <= e_nx[k];
                    if (finish) begin
                        bus.O         <= o_nx;
                        bus.OUT_VALID <= 1'b1;
                        bus.BUSY      <= 1'b0;
                        state         <= DONE;
                    end else if (pass_end) begin
                        p <= p + CW'(1);
                        j <= '0;
`ifdef SORT_EARLY_EXIT_EN
                        swapped <= 1'b0;
`endif
                    end else begin
                        j <= jn;
`ifdef SORT_EARLY_EXIT_EN
                        swapped <= swapped | c;
`endif
                    end
                end
                DONE: begin
                    if (bus.OUT_READY) begin
                        bus.OUT_VALID <= 1'b0;
                        bus.IN_READY  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ult_sort_sequencer.sv
// Directed and random checks of ult_sort_sequencer against a sorted-queue reference model.
module tb_ult_sort_sequencer;
    localparam int W = 4;
    localparam int N = 4;

    logic CLK = 1'b0;
    logic RESET;
    int   n_assert = 0;
    int   n_fail   = 0;

    ult_sort_sequencer_if #(.WIDTH(W), .N(N)) bus ();
    ult_sort_sequencer #(.WIDTH(W), .N(N)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [3:0] v0, v1, v2, v3;
        v0 = a0[3:0]; v1 = a1[3:0]; v2 = a2[3:0]; v3 = a3[3:0];
        return {v3, v2, v1, v0};
    endfunction

    function automatic logic [N*W-1:0] model_sort(input logic [N*W-1:0] blk);
        int q[$];
        for (int k = 0; k < N; k++) q.push_back(int'(blk[k*W +: W]));
        q.sort();
        return pack4(q[0], q[1], q[2], q[3]);
    endfunction

    // Bubble sort needs as many passes as the largest count of bigger elements sitting left of any element.
    function automatic int model_lat(input logic [N*W-1:0] blk);
`ifdef SORT_EARLY_EXIT_EN
        int worst, cnt, passes, total;
        worst = 0;
        for (int k = 0; k < N; k++) begin
            cnt = 0;
            for (int m = 0; m < k; m++)
                if (blk[m*W +: W] > blk[k*W +: W]) cnt++;
            if (cnt > worst) worst = cnt;
        end
        passes = (worst + 1 > N - 1) ? N - 1 : worst + 1;
        total = 0;
        for (int q = 0; q < passes; q++) total += N - 1 - q;
        return total;
`else
        return blk == '0 ? N * (N - 1) / 2 : N * (N - 1) / 2;
`endif
    endfunction

    task automatic run_block(input logic [N*W-1:0] blk, input int hold);
        logic [N*W-1:0] exp;
        int lat;
        exp = model_sort(blk);
        @(negedge CLK);
        chk("in_ready_idle", 32'(bus.IN_READY), 32'd1);
        bus.IN_VALID  = 1'b1;
        bus.I         = blk;
        bus.OUT_READY = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        bus.I = N*W'($urandom);
        bus.OUT_READY = 1'($urandom);
        lat = 0;
        do begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (!bus.OUT_VALID) begin
                chk("busy_sort", 32'(bus.BUSY), 32'd1);
                chk("in_ready_sort", 32'(bus.IN_READY), 32'd0);
                bus.I = N*W'($urandom);
                bus.OUT_READY = 1'($urandom);
            end
        end while (!bus.OUT_VALID && lat < 40);
        bus.OUT_READY = 1'b0;
        chk("latency", 32'(lat), 32'(model_lat(blk)));
        chk("sorted_o", 32'(bus.O), 32'(exp));
        chk("busy_done", 32'(bus.BUSY), 32'd0);
        repeat (hold) begin
            @(negedge CLK);
            chk("hold_valid", 32'(bus.OUT_VALID), 32'd1);
            chk("hold_o", 32'(bus.O), 32'(exp));
            chk("in_ready_done", 32'(bus.IN_READY), 32'd0);
            bus.I = N*W'($urandom);
        end
        bus.OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        chk("valid_after_take", 32'(bus.OUT_VALID), 32'd0);
        chk("in_ready_after_take", 32'(bus.IN_READY), 32'd1);
    endtask

    initial begin
        RESET         = 1'b1;
        bus.IN_VALID  = 1'b0;
        bus.I         = '0;
        bus.OUT_READY = 1'b0;
        #12 RESET = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_o", 32'(bus.O), 32'd0);
        chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);

        run_block(pack4(15, 10, 5, 0), 0);
        run_block(pack4(8, 7, 8, 0), 2);
        run_block(pack4(15, 0, 15, 0), 1);
        run_block(pack4(1, 2, 3, 4), 5);
        for (int r = 0; r < 10; r++) run_block(N*W'($urandom), int'($urandom_range(0, 3)));

        @(negedge CLK);
        bus.IN_VALID = 1'b1;
        bus.I        = pack4(15, 10, 5, 0);
        @(posedge CLK);
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("midrst_busy", 32'(bus.BUSY), 32'd0);
        chk("midrst_o", 32'(bus.O), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(bus.IN_READY), 32'd1);
        run_block(pack4(3, 1, 2, 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
